// File: rtl/pcm_to_i2s.sv
`default_nettype none
// ============================================================================
// Module   : pcm_to_i2s
// Purpose  : Stereo PCM pair to I2S serialiser with one-pair holding buffer,
//            underrun detection and a saturating underrun counter.
// Revision : 1.0
// ============================================================================
module pcm_to_i2s #(
    parameter int NUMBER_OF_BITS = 8,
    parameter int HALF_FRAME     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUMBER_OF_BITS-1:0] in_left,
    input  logic [NUMBER_OF_BITS-1:0] in_right,
    output logic                      ws,
    output logic                      sd,
    output logic                      underrun,
    output logic [7:0]                underrun_count
);

    localparam int            CW     = (HALF_FRAME > 1) ? $clog2(HALF_FRAME) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(HALF_FRAME - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                    state_q;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      ws_q, ws_d;
    logic                      sd_q, sd_d;
    logic                      hold_full_q, hold_full_d;
    logic [NUMBER_OF_BITS-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [NUMBER_OF_BITS-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
    logic                      underrun_q, underrun_d;
    logic [7:0]                urcnt_q, urcnt_d;

    logic                      last_cyc;
    logic                      load_evt;
    logic                      accept;
    logic [NUMBER_OF_BITS-1:0] tx_word;

    always_comb begin
        last_cyc    = (cnt_q == C_LAST);
        load_evt    = last_cyc & ws_q;
        accept      = in_valid & ~hold_full_q;

        cnt_d       = last_cyc ? '0 : cnt_q + 1'b1;
        ws_d        = last_cyc ? ~ws_q : ws_q;

        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        act_l_d     = act_l_q;
        act_r_d     = act_r_q;

        // Load sees the pre-edge hold state, so a same-edge accept is kept for the next frame.
        if (load_evt) begin
            if (hold_full_q) begin
                act_l_d     = hold_l_q;
                act_r_d     = hold_r_q;
                hold_full_d = 1'b0;
            end else begin
                act_l_d = '0;
                act_r_d = '0;
            end
        end
        if (accept) begin
            hold_l_d    = in_left;
            hold_r_d    = in_right;
            hold_full_d = 1'b1;
        end

        underrun_d = load_evt & ~hold_full_q & (state_q == S_RUN);
        urcnt_d    = (underrun_d && (urcnt_q != 8'hFF)) ? urcnt_q + 8'd1 : urcnt_q;

        // Data lags ws by one bit: post-edge count 1 carries the MSB.
        tx_word = ws_d ? act_r_d : act_l_d;
        sd_d    = 1'b0;
        for (int i = 0; i < NUMBER_OF_BITS; i++) begin
            if (cnt_d == CW'(NUMBER_OF_BITS - i)) begin
                sd_d = tx_word[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ws_q        <= 1'b0;
            sd_q        <= 1'b0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            act_l_q     <= '0;
            act_r_q     <= '0;
            underrun_q  <= 1'b0;
            urcnt_q     <= 8'd0;
        end else begin
            if (accept) begin
                state_q <= S_RUN;
            end
            cnt_q       <= cnt_d;
            ws_q        <= ws_d;
            sd_q        <= sd_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            act_l_q     <= act_l_d;
            act_r_q     <= act_r_d;
            underrun_q  <= underrun_d;
            urcnt_q     <= urcnt_d;
        end
    end

    assign in_ready       = ~hold_full_q;
    assign ws             = ws_q;
    assign sd             = sd_q;
    assign underrun       = underrun_q;
    assign underrun_count = urcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pcm_to_i2s.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcm_to_i2s
// Purpose  : Directed, table-driven self-checking bench for pcm_to_i2s.
// Revision : 1.0
// ============================================================================
module tb_pcm_to_i2s;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_left = 8'd0;
    logic [7:0] in_right = 8'd0;
    logic       in_ready;
    logic       ws;
    logic       sd;
    logic       underrun;
    logic [7:0] underrun_count;

    int errors = 0;
    int checks = 0;
    int e = -1;

    typedef struct {
        int         at;
        bit         v;
        logic [7:0] l;
        logic [7:0] r;
        bit         ws;
        bit         sd;
        bit         rdy;
        bit         ur;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    pcm_to_i2s #(
        .NUMBER_OF_BITS(8),
        .HALF_FRAME    (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_left       (in_left),
        .in_right      (in_right),
        .ws            (ws),
        .sd            (sd),
        .underrun      (underrun),
        .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
        e++;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, e, act, exp_v);
        end
    endtask

    task automatic add(input int at, input bit v, input logic [7:0] l, input logic [7:0] r,
                       input bit ws_e, input bit sd_e, input bit rdy_e, input bit ur_e, input int cnt_e);
        vec_t x;
        x.at = at; x.v = v; x.l = l; x.r = r;
        x.ws = ws_e; x.sd = sd_e; x.rdy = rdy_e; x.ur = ur_e; x.cnt = cnt_e;
        tbl.push_back(x);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        e = -1;
    endtask

    task automatic idle_run(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            step();
            chk({tag, "_ws"}, int'(ws), ((e + 1) >> 5) & 1);
            chk({tag, "_sd"}, int'(sd), 0);
            chk({tag, "_underrun"}, int'(underrun), 0);
            chk({tag, "_ready"}, int'(in_ready), 1);
        end
    endtask

    initial begin
        logic [7:0] bl;
        logic [7:0] br;
        int         pulses;
        bl = 8'hA5;
        br = 8'h3C;

        add(0,   1, 8'hA5, 8'h3C, 0, 0, 1, 0, 0);
        add(1,   0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        add(31,  0, 8'h00, 8'h00, 1, 0, 0, 0, 0);
        add(63,  1, 8'h81, 8'h7E, 0, 0, 1, 0, 0);
        for (int k = 0; k < 8; k++)
            add(64 + k, 1, (k >= 6) ? 8'h55 : 8'h81, (k >= 6) ? 8'hAA : 8'h7E, 0, bl[7-k], 0, 0, 0);
        add(72,  1, 8'h55, 8'hAA, 0, 0, 0, 0, 0);
        add(95,  1, 8'h55, 8'hAA, 1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            add(96 + k, 1, 8'h55, 8'hAA, 1, br[7-k], 0, 0, 0);
        add(104, 1, 8'h55, 8'hAA, 1, 0, 0, 0, 0);
        add(126, 1, 8'h55, 8'hAA, 1, 0, 0, 0, 0);
        add(127, 1, 8'h55, 8'hAA, 0, 0, 1, 0, 0);
        add(128, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0);
        add(129, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        add(135, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0);
        add(160, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0);
        add(161, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0);
        add(191, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0);
        add(192, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0);
        add(193, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0);
        add(254, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0);
        add(255, 0, 8'h00, 8'h00, 0, 0, 1, 1, 1);
        add(256, 0, 8'h00, 8'h00, 0, 0, 1, 0, 1);
        add(257, 0, 8'h00, 8'h00, 0, 0, 1, 0, 1);
        add(260, 0, 8'h00, 8'h00, 0, 0, 1, 0, 1);
        add(288, 0, 8'h00, 8'h00, 1, 0, 1, 0, 1);
        add(318, 1, 8'hF0, 8'h0F, 1, 0, 1, 0, 1);
        add(319, 0, 8'h00, 8'h00, 0, 0, 0, 1, 2);
        add(320, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2);
        add(321, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2);
        add(383, 0, 8'h00, 8'h00, 0, 0, 1, 0, 2);
        add(384, 0, 8'h00, 8'h00, 0, 1, 1, 0, 2);
        add(388, 0, 8'h00, 8'h00, 0, 0, 1, 0, 2);
        add(416, 0, 8'h00, 8'h00, 1, 0, 1, 0, 2);
        add(420, 0, 8'h00, 8'h00, 1, 1, 1, 0, 2);

        // Idle: never accepting a pair must never flag underrun.
        do_reset();
        idle_run("idle", 130);

        // Serialisation, back-pressure, underrun and coincident accept/load.
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            while (e < tbl[i].at) step();
            chk("ws", int'(ws), int'(tbl[i].ws));
            chk("sd", int'(sd), int'(tbl[i].sd));
            chk("in_ready", int'(in_ready), int'(tbl[i].rdy));
            chk("underrun", int'(underrun), int'(tbl[i].ur));
            chk("underrun_count", int'(underrun_count), tbl[i].cnt);
            in_valid = tbl[i].v;
            in_left  = tbl[i].l;
            in_right = tbl[i].r;
        end

        // 300 consecutive underrunning frames: one-cycle pulses, count saturates.
        pulses = 0;
        for (int k = 0; k < 300 * 64; k++) begin
            step();
            if (underrun) pulses++;
        end
        chk("underrun_pulses", pulses, 300);
        chk("underrun_count_sat", int'(underrun_count), 255);

        // Async reset in the middle of a right-channel word (cnt = 4).
        in_valid = 1'b1;
        in_left  = 8'hFF;
        in_right = 8'hFF;
        step();
        chk("accept_ff", int'(in_ready), 0);
        in_valid = 1'b0;
        for (int n = 0; n < 200 && (e % 64) != 63; n++) step();
        chk("align_load", e % 64, 63);
        for (int n = 0; n < 200 && (e % 64) != 35; n++) step();
        chk("pre_rst_ws", int'(ws), 1);
        chk("pre_rst_sd", int'(sd), 1);
        chk("pre_rst_count", int'(underrun_count), 255);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ws", int'(ws), 0);
        chk("rst_sd", int'(sd), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_count", int'(underrun_count), 0);
        step();
        chk("rst_hold_ws", int'(ws), 0);
        chk("rst_hold_sd", int'(sd), 0);
        rst_n = 1'b1;
        e = -1;
        idle_run("post_rst", 130);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcm_to_i2s.md
PCM_TO_I2S -- requirements
Module: pcm_to_i2s

Interface
REQ-001 SHALL have parameter NUMBER_OF_BITS, default 8, sample width per channel.
REQ-002 SHALL have parameter HALF_FRAME, default 32, clk cycles per ws half-period; legal only if HALF_FRAME >= NUMBER_OF_BITS+1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers a stereo sample pair.
REQ-006 SHALL have port in_ready  output  1  block can accept the offered pair.
REQ-007 SHALL have port in_left  input  NUMBER_OF_BITS  left-channel PCM word.
REQ-008 SHALL have port in_right  input  NUMBER_OF_BITS  right-channel PCM word.
REQ-009 SHALL have port ws  output  1  I2S word select; 0 = left, 1 = right.
REQ-010 SHALL have port sd  output  1  I2S serial data, MSB first.
REQ-011 SHALL have port underrun  output  1  one-cycle pulse, frame started with no new pair.
REQ-012 SHALL have port underrun_count  output  8  saturating count of underrun pulses.

Function
REQ-013 SHALL keep half-frame counter cnt, 0..HALF_FRAME-1, incrementing every cycle and wrapping to 0.
REQ-014 SHALL toggle ws on the edge where cnt == HALF_FRAME-1.
REQ-015 SHALL drive sd = bit (NUMBER_OF_BITS-cnt) of current-channel active word when 1 <= cnt <= NUMBER_OF_BITS, else 0; one-bit delay after each ws transition, per I2S.
REQ-016 SHALL select active_left when ws=0, active_right when ws=1; all outputs registered.
REQ-017 SHALL hold one pair in a holding register with flag hold_full; in_ready = !hold_full.
REQ-018 SHALL accept a pair (in_valid && in_ready) into the holding register and set hold_full on that edge.
REQ-019 SHALL define load event as the edge where cnt == HALF_FRAME-1 and ws == 1 (ws about to fall, new frame).
REQ-020 SHALL at a load event with hold_full=1 copy hold to active pair and clear hold_full.
REQ-021 SHALL at a load event with hold_full=0 load active pair with zeros; underrun pulse only in state RUN.
REQ-022 SHALL, when accept and load event coincide, evaluate the load against pre-edge hold_full (=0, so zeros/underrun) and store the accepted pair in hold for the next frame.
REQ-023 SHALL implement FSM IDLE -> RUN on first accepted pair; RUN stays until reset; IDLE never flags underrun.
REQ-024 SHALL assert underrun for exactly the cycle after the underrunning load event, increment underrun_count, saturate at 255.
REQ-025 SHALL not alter active words mid-frame; in_left/in_right changes while not accepted have no effect.

Reset
REQ-026 SHALL on rst_n=0 immediately force: ws=0, sd=0, cnt=0, in_ready=1, hold_full=0, underrun=0, underrun_count=0, active pair=0, state IDLE.
REQ-027 SHALL after rst_n release start counting with cnt=0 in left half on the first rising clk edge; reset mid-frame discards in-flight and held data.

Verification (NUMBER_OF_BITS=8, HALF_FRAME=32, cycle 0 = first edge after release)
REQ-028 SHALL verify idle: no in_valid -> ws rises after edge 31, falls after edge 63, period 64; sd=0, underrun=0 throughout.
REQ-029 SHALL verify serialisation: accept L=0xA5, R=0x3C before edge 63 -> sd after edges 64..71 = 1,0,1,0,0,1,0,1 (ws=0); after edges 96..103 = 0,0,1,1,1,1,0,0 (ws=1); sd=0 elsewhere.
REQ-030 SHALL verify back-pressure: second pair offered while hold_full -> in_ready=0 until load event, pair accepted the cycle after, transmitted the following frame.
REQ-031 SHALL verify underrun: RUN with no pair before a load event -> underrun=1 one cycle, next frame sd all 0, underrun_count=1; 300 consecutive underruns -> count=255.
REQ-032 SHALL verify simultaneous accept and load event -> underrun pulse, zero frame, accepted pair sent in the following frame.
REQ-033 SHALL verify async reset mid-word (cnt=4): outputs cleared before next clk edge, in_ready=1, underrun_count=0, state IDLE.
